// File: rtl/y_sobel_edge.sv
// Streaming 3x3 Sobel edge detector on luma: two line buffers, a 3x3 window,
// |Gx|+|Gy| magnitude saturated to 8 bits plus a per-frame thresholded edge flag.
module y_sobel_edge #(
    parameter int IMG_WIDTH = 640,
    parameter int COL_W     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_Y_8b,
    input  logic        i_h_sync,
    input  logic        i_v_sync,
    input  logic        i_data_en,
    input  logic [10:0] i_thresh_11b,
    output logic [7:0]  o_mag_8b,
    output logic        o_edge_1b,
    output logic        o_h_sync,
    output logic        o_v_sync,
    output logic        o_data_en
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

    logic [COL_W-1:0] r_col;
    logic             r_col_ovf;
    logic [1:0]       r_row;
    logic             r_de_prev;
    logic             r_vs_prev;
    logic [10:0]      r_thr;

    logic [7:0]       r_lb1 [0:IMG_WIDTH-1];
    logic [7:0]       r_lb2 [0:IMG_WIDTH-1];
    logic [7:0]       r_win [0:2][0:2];

    logic [9:0]       r_right;
    logic [9:0]       r_left;
    logic [9:0]       r_bottom;
    logic [9:0]       r_top;

    logic [10:0]      r_abs_gx;
    logic [10:0]      r_abs_gy;

    logic [7:0]       r_mag;
    logic             r_edge;

    logic [3:0]       r_de_dly;
    logic [3:0]       r_hs_dly;
    logic [3:0]       r_vs_dly;
    logic [2:0]       r_bord_dly;

    logic             w_accept;
    logic             w_border;
    logic [7:0]       w_lb1_rd;
    logic [7:0]       w_lb2_rd;
    logic [9:0]       w_right;
    logic [9:0]       w_left;
    logic [9:0]       w_bottom;
    logic [9:0]       w_top;
    logic signed [10:0] w_gx;
    logic signed [10:0] w_gy;
    logic [10:0]      w_gx_abs;
    logic [10:0]      w_gy_abs;
    logic [10:0]      w_sum;
    logic [7:0]       w_sat;
    logic             w_out_valid;

    // Pixels past the last buffer column are dropped and reported as border.
    assign w_accept = i_data_en && !r_col_ovf;
    assign w_border = (r_row < 2'd2) || (r_col < COL_W'(2)) || r_col_ovf;
    assign w_lb1_rd = r_lb1[r_col];
    assign w_lb2_rd = r_lb2[r_col];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_col_ovf <= 1'b0;
            r_row     <= 2'd0;
            r_de_prev <= 1'b0;
            r_vs_prev <= 1'b0;
            r_thr     <= 11'd2047;
        end else begin
            r_de_prev <= i_data_en;
            r_vs_prev <= i_v_sync;
            if (i_v_sync && !r_vs_prev) begin
                r_thr <= i_thresh_11b;
            end
            if (i_data_en) begin
                if (r_col == LAST_COL) begin
                    r_col_ovf <= 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_col     <= '0;
                r_col_ovf <= 1'b0;
            end
            if (i_v_sync) begin
                r_row <= 2'd0;
            end else if (r_de_prev && !i_data_en && (r_row != 2'd3)) begin
                r_row <= r_row + 2'd1;
            end
        end
    end

    // Read-before-write: LB2 inherits the line LB1 held before this pixel.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_col] <= i_Y_8b;
            r_lb2[r_col] <= w_lb1_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= 8'd0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb2_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= i_Y_8b;
        end
    end

    assign w_right  = {2'b00, r_win[0][2]} + {1'b0, r_win[1][2], 1'b0} + {2'b00, r_win[2][2]};
    assign w_left   = {2'b00, r_win[0][0]} + {1'b0, r_win[1][0], 1'b0} + {2'b00, r_win[2][0]};
    assign w_bottom = {2'b00, r_win[2][0]} + {1'b0, r_win[2][1], 1'b0} + {2'b00, r_win[2][2]};
    assign w_top    = {2'b00, r_win[0][0]} + {1'b0, r_win[0][1], 1'b0} + {2'b00, r_win[0][2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_right  <= 10'd0;
            r_left   <= 10'd0;
            r_bottom <= 10'd0;
            r_top    <= 10'd0;
        end else begin
            r_right  <= w_right;
            r_left   <= w_left;
            r_bottom <= w_bottom;
            r_top    <= w_top;
        end
    end

    assign w_gx     = $signed({1'b0, r_right}) - $signed({1'b0, r_left});
    assign w_gy     = $signed({1'b0, r_bottom}) - $signed({1'b0, r_top});
    assign w_gx_abs = w_gx[10] ? -w_gx : w_gx;
    assign w_gy_abs = w_gy[10] ? -w_gy : w_gy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_abs_gx <= 11'd0;
            r_abs_gy <= 11'd0;
        end else begin
            r_abs_gx <= w_gx_abs;
            r_abs_gy <= w_gy_abs;
        end
    end

    // Each absolute gradient is at most 1020, so the 11-bit sum cannot wrap.
    assign w_sum       = r_abs_gx + r_abs_gy;
    assign w_sat       = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
    assign w_out_valid = r_de_dly[2] && !r_bord_dly[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag  <= 8'd0;
            r_edge <= 1'b0;
        end else begin
            r_mag  <= w_out_valid ? w_sat : 8'd0;
            r_edge <= w_out_valid && (w_sum >= r_thr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de_dly   <= 4'd0;
            r_hs_dly   <= 4'd0;
            r_vs_dly   <= 4'd0;
            r_bord_dly <= 3'd0;
        end else begin
            r_de_dly   <= {r_de_dly[2:0], i_data_en};
            r_hs_dly   <= {r_hs_dly[2:0], i_h_sync};
            r_vs_dly   <= {r_vs_dly[2:0], i_v_sync};
            r_bord_dly <= {r_bord_dly[1:0], w_border};
        end
    end

    assign o_mag_8b  = r_mag;
    assign o_edge_1b = r_edge;
    assign o_h_sync  = r_hs_dly[3];
    assign o_v_sync  = r_vs_dly[3];
    assign o_data_en = r_de_dly[3];

endmodule

// File: tb/tb_y_sobel_edge.sv
// Self-checking bench for y_sobel_edge: frame table plus hand-written reset
// sequence, with a per-cycle scoreboard fed from a direct 2-D Sobel reference.
module tb_y_sobel_edge;

    localparam int W      = 16;
    localparam int NLINES = 8;
    localparam int MAXLEN = 20;

    logic        clk;
    logic        rst;
    logic [7:0]  yIn;
    logic        hsIn;
    logic        vsIn;
    logic        deIn;
    logic [10:0] thresh;
    logic [7:0]  oMag;
    logic        oEdge;
    logic        oHs;
    logic        oVs;
    logic        oDe;

    y_sobel_edge #(.IMG_WIDTH(W), .COL_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .i_Y_8b(yIn),
        .i_h_sync(hsIn),
        .i_v_sync(vsIn),
        .i_data_en(deIn),
        .i_thresh_11b(thresh),
        .o_mag_8b(oMag),
        .o_edge_1b(oEdge),
        .o_h_sync(oHs),
        .o_v_sync(oVs),
        .o_data_en(oDe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum logic [1:0] {PAT_FLAT, PAT_VSTEP, PAT_HSTEP, PAT_CHECK} pattern_t;

    typedef struct {
        logic       de;
        logic       hs;
        logic       vs;
        logic [7:0] mag;
        logic       edgeFlag;
    } expRec_t;

    typedef struct {
        pattern_t pat;
        int       len;
        int       thrStart;
        int       thrMid;
        int       expEdges;
        int       expMax;
    } frameVec_t;

    expRec_t sbQueue[$];
    int      nVectors;
    int      nMiscompares;
    int      frameEdges;
    int      frameMax;
    int      thrModel;
    int      modelRow;
    int      img [0:NLINES-1][0:MAXLEN-1];

    function automatic expRec_t mkRec(input logic de, input logic hs, input logic vs,
                                      input int mag, input logic edgeFlag);
        expRec_t e;
        e.de       = de;
        e.hs       = hs;
        e.vs       = vs;
        e.mag      = 8'(mag);
        e.edgeFlag = edgeFlag;
        return e;
    endfunction

    function automatic frameVec_t mkVec(input pattern_t pat, input int len, input int thrStart,
                                        input int thrMid, input int expEdges, input int expMax);
        frameVec_t v;
        v.pat      = pat;
        v.len      = len;
        v.thrStart = thrStart;
        v.thrMid   = thrMid;
        v.expEdges = expEdges;
        v.expMax   = expMax;
        return v;
    endfunction

    function automatic int pixVal(input pattern_t p, input int r, input int c);
        case (p)
            PAT_FLAT:  return 80;
            PAT_VSTEP: return (c < 8) ? 0 : 100;
            PAT_HSTEP: return (r < 4) ? 0 : 10;
            default:   return ((((r >> 1) + (c >> 1)) & 1) != 0) ? 255 : 0;
        endcase
    endfunction

    // Output for a pixel accepted at (r, c) is the Sobel result centred at (r-1, c-1).
    function automatic expRec_t modelPixel(input int r, input int c);
        int gx;
        int gy;
        int raw;
        if (r < 2 || c < 2 || c >= W) begin
            return mkRec(1'b1, 1'b0, 1'b0, 0, 1'b0);
        end
        gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        raw = gx + gy;
        return mkRec(1'b1, 1'b0, 1'b0, (raw > 255) ? 255 : raw, raw >= thrModel);
    endfunction

    task automatic checkOutput(input expRec_t e);
        nVectors++;
        if (oDe !== e.de || oHs !== e.hs || oVs !== e.vs || oMag !== e.mag || oEdge !== e.edgeFlag) begin
            nMiscompares++;
            $display("[TB] FAIL scoreboard t=%0t: got de=%b hs=%b vs=%b mag=%0d edge=%b, want de=%b hs=%b vs=%b mag=%0d edge=%b",
                     $time, oDe, oHs, oVs, oMag, oEdge, e.de, e.hs, e.vs, e.mag, e.edgeFlag);
        end
        if (oEdge === 1'b1) frameEdges++;
        if (int'(oMag) > frameMax) frameMax = int'(oMag);
    endtask

    // A reset cycle clears the whole pipeline, so every in-flight expectation becomes zero.
    task automatic applyStimulus(input logic rIn, input logic vIn, input logic hIn, input logic dIn,
                                 input logic [7:0] yv, input expRec_t e);
        rst  = rIn;
        vsIn = vIn;
        hsIn = hIn;
        deIn = dIn;
        yIn  = yv;
        if (rIn) begin
            foreach (sbQueue[i]) sbQueue[i] = mkRec(1'b0, 1'b0, 1'b0, 0, 1'b0);
            sbQueue.push_back(mkRec(1'b0, 1'b0, 1'b0, 0, 1'b0));
        end else begin
            sbQueue.push_back(e);
        end
        @(posedge clk);
        #1;
        if (sbQueue.size() == 4) checkOutput(sbQueue.pop_front());
    endtask

    task automatic blankStep(input logic h, input logic v);
        applyStimulus(1'b0, v, h, 1'b0, 8'd0, mkRec(1'b0, h, v, 0, 1'b0));
    endtask

    task automatic driveFrame(input pattern_t pat, input int len, input int thrStart,
                              input int thrMid, input int resetLine, input int resetPix);
        bit      resetHit;
        int      y;
        expRec_t e;
        resetHit   = 1'b0;
        frameEdges = 0;
        frameMax   = 0;
        thresh     = 11'(thrStart);
        blankStep(1'b0, 1'b0);
        blankStep(1'b0, 1'b0);
        thrModel = thrStart;
        modelRow = 0;
        blankStep(1'b0, 1'b1);
        blankStep(1'b0, 1'b1);
        repeat (3) blankStep(1'b0, 1'b0);
        for (int l = 0; l < NLINES; l++) begin
            blankStep(1'b1, 1'b0);
            blankStep(1'b1, 1'b0);
            blankStep(1'b0, 1'b0);
            for (int c = 0; c < len; c++) begin
                if (thrMid >= 0 && l == 2 && c == 0) thresh = 11'(thrMid);
                y = pixVal(pat, l, c);
                if (l == resetLine && c == resetPix) begin
                    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'(y), mkRec(1'b0, 1'b0, 1'b0, 0, 1'b0));
                    thrModel = 2047;
                    modelRow = 0;
                    resetHit = 1'b1;
                    nVectors++;
                    if (oDe !== 1'b0 || oMag !== 8'd0) begin
                        nMiscompares++;
                        $display("[TB] FAIL reset-clears: got de=%b mag=%0d, want de=0 mag=0", oDe, oMag);
                    end
                end else begin
                    img[modelRow][c] = y;
                    e = modelPixel(modelRow, c);
                    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'(y), e);
                end
            end
            repeat (6) blankStep(1'b0, 1'b0);
            modelRow++;
            if (resetHit) break;
        end
    endtask

    task automatic checkFrame(input string name, input int expEdges, input int expMax);
        if (expEdges >= 0) begin
            nVectors++;
            if (frameEdges != expEdges) begin
                nMiscompares++;
                $display("[TB] FAIL %s edge-count: got %0d, want %0d", name, frameEdges, expEdges);
            end
        end
        nVectors++;
        if (frameMax != expMax) begin
            nMiscompares++;
            $display("[TB] FAIL %s max-mag: got %0d, want %0d", name, frameMax, expMax);
        end
    endtask

    frameVec_t vecs [6];

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        thrModel     = 2047;
        modelRow     = 0;
        thresh       = 11'd0;

        vecs[0] = mkVec(PAT_FLAT,  16,   1, -1,  0,   0);
        vecs[1] = mkVec(PAT_VSTEP, 16, 200, -1, 12, 255);
        vecs[2] = mkVec(PAT_HSTEP, 16,  40, -1, 28,  40);
        vecs[3] = mkVec(PAT_VSTEP, 16, 200, 500, 12, 255);
        vecs[4] = mkVec(PAT_VSTEP, 16, 500, -1,  0, 255);
        vecs[5] = mkVec(PAT_CHECK, 20, 300, -1, -1, 255);

        $display("[TB] start");
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, mkRec(1'b0, 1'b0, 1'b0, 0, 1'b0));
        repeat (3) blankStep(1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            driveFrame(vecs[i].pat, vecs[i].len, vecs[i].thrStart, vecs[i].thrMid, -1, -1);
            checkFrame($sformatf("frame%0d", i), vecs[i].expEdges, vecs[i].expMax);
        end

        driveFrame(PAT_VSTEP, 16, 200, -1, 3, 5);
        driveFrame(PAT_VSTEP, 16, 200, -1, -1, -1);
        checkFrame("post-reset", 12, 255);

        repeat (8) blankStep(1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
